// File: rtl/add_seq128.sv
// -----------------------------------------------------------------------------
// add_seq128 -- multi-word sequential adder.
//
// Adds two W-bit operands (W = 32*WORDS) plus a carry-in, one 32-bit word per
// clock. Each word goes through an external combinational 32-bit adder.
// An accepted request takes WORDS RUN cycles, then the block holds the sum in
// DONE until the consumer acknowledges it.
//
// Ports:
//   clock, reset_n        sole clock (rising edge), async active-low reset
//   start / ready         request handshake; ready only in IDLE and out of reset
//   opA, opB, carry_in    operands, latched on the accepting edge
//   add_a, add_b, add_cin word-slice and carry driven to the external adder
//   add_sum, add_cout     combinational results from the external adder
//   result, carry_out     assembled W-bit sum and final carry
//   done / ack            result valid; ack in DONE releases the block to IDLE
// -----------------------------------------------------------------------------
module add_seq128 #(
  parameter int unsigned WORDS = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  ready,
  input  logic [32*WORDS-1:0]   opA,
  input  logic [32*WORDS-1:0]   opB,
  input  logic                  carry_in,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  output logic                  add_cin,
  input  logic [31:0]           add_sum,
  input  logic                  add_cout,
  output logic [32*WORDS-1:0]   result,
  output logic                  carry_out,
  output logic                  done,
  input  logic                  ack
);

  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Operands and result are viewed as arrays of 32-bit words so the word
  // select is a plain index rather than a computed bit offset.
  typedef logic [WORDS-1:0][31:0] words_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  words_t           a_q,     a_d;
  words_t           b_q,     b_d;
  logic             cin_q,   cin_d;     // latched carry_in
  logic             carry_q, carry_d;   // carry between words
  words_t           result_q, result_d;
  logic             cout_q,  cout_d;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    add_a    = '0;
    add_b    = '0;
    add_cin  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = opA;
          b_d      = opB;
          cin_d    = carry_in;
          carry_d  = 1'b0;
          result_d = '0;
          cout_d   = 1'b0;
          idx_d    = '0;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        add_a   = a_q[idx_q];
        add_b   = b_q[idx_q];
        // The first word takes the external carry; later words chain the
        // carry produced by the word before.
        add_cin = (idx_q == '0) ? cin_q : carry_q;

        result_d[idx_q] = add_sum;
        carry_d         = add_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_cout;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      S_DONE: begin
        // ack wins over a simultaneous start; the request is simply not seen.
        if (ack) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the operand and result registers are reset along with the control
  // state, because an abandoned operation must leave nothing visible on result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  // ready also looks at reset_n directly so it drops the moment reset asserts.
  assign ready     = (state_q == S_IDLE) && reset_n;
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_add_seq128.sv
// -----------------------------------------------------------------------------
// tb_add_seq128 -- self-checking bench for add_seq128.
//
// A combinational 32-bit adder stands in for the downstream adder. A
// behavioural model tracks where an operation should be (idle, RUN word k,
// done) and derives every expected output from plain W-bit arithmetic on the
// latched operands. A compare process checks the DUT against it every cycle;
// directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_add_seq128;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 32 * WORDS;

  logic          clock;
  logic          reset_n;
  logic          start;
  logic          ready;
  logic [W-1:0]  opA;
  logic [W-1:0]  opB;
  logic          carry_in;
  logic [31:0]   add_a;
  logic [31:0]   add_b;
  logic          add_cin;
  logic [31:0]   add_sum;
  logic          add_cout;
  logic [W-1:0]  result;
  logic          carry_out;
  logic          done;
  logic          ack;

  int errors = 0;
  int checks = 0;

  add_seq128 #(.WORDS(WORDS)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .ready     (ready),
    .opA       (opA),
    .opB       (opB),
    .carry_in  (carry_in),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .result    (result),
    .carry_out (carry_out),
    .done      (done),
    .ack       (ack)
  );

  // Downstream 32-bit adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: phase 0 = idle, 1..WORDS = working on word phase-1,
  // WORDS+1 = result held.
  // ---------------------------------------------------------------------------
  int           m_phase;
  logic [W-1:0] m_a, m_b;
  logic         m_c;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_phase <= 0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_a     <= opA;
        m_b     <= opB;
        m_c     <= carry_in;
        m_phase <= 1;
      end
    end else if (m_phase <= WORDS) begin
      m_phase <= m_phase + 1;
    end else if (ack) begin
      m_phase <= 0;
    end
  end

  function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  // Carry entering word j = bit 32*j of the sum of the lower j words.
  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic c, input int j);
    logic [W:0] mask;
    logic [W:0] s;
    if (j == 0) return c;
    mask = ({{W{1'b0}}, 1'b1} << (32 * j)) - 1'b1;
    s    = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {{W{1'b0}}, c};
    return s[32*j];
  endfunction

  logic [WORDS-1:0] obs_cin;   // add_cin seen on each word of the last op

  always @(negedge clock) begin
    if (!reset_n) begin
      check("rst_ready", 256'(ready), 256'(0));
      check("rst_done", 256'(done), 256'(0));
      check("rst_result", 256'({carry_out, result}), 256'(0));
      check("rst_add", 256'({add_cin, add_a, add_b}), 256'(0));
    end else begin
      check("ready", 256'(ready), 256'(m_phase == 0));
      check("done", 256'(done), 256'(m_phase == WORDS + 1));
      if (m_phase == WORDS + 1) begin
        check("sum", 256'({carry_out, result}), 256'(model_sum(m_a, m_b, m_c)));
      end
      if (m_phase >= 1 && m_phase <= WORDS) begin
        int j;
        j = m_phase - 1;
        check("add_a", 256'(add_a), 256'(m_a[32*j +: 32]));
        check("add_b", 256'(add_b), 256'(m_b[32*j +: 32]));
        check("add_cin", 256'(add_cin), 256'(carry_into(m_a, m_b, m_c, j)));
        obs_cin[j] = add_cin;
      end else begin
        check("add_idle", 256'({add_cin, add_a, add_b}), 256'(0));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers. All are entered and left at #1 after a rising edge.
  // ---------------------------------------------------------------------------
  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    for (int i = 0; i < WORDS; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Present a request for one edge, then scramble the operand inputs.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    opA      = a;
    opB      = b;
    carry_in = c;
    start    = 1'b1;
    @(posedge clock); #1;
    start    = 1'b0;
    opA      = rand_w();
    opB      = rand_w();
    carry_in = 1'($urandom);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 3 * WORDS + 4) begin
      @(posedge clock); #1;
      n++;
    end
    check("done_reached", 256'(done === 1'b1), 256'(1));
  endtask

  task automatic give_ack();
    ack = 1'b1;
    @(posedge clock); #1;
    ack = 1'b0;
  endtask

  initial begin
    int n;
    logic [W-1:0] ones;
    ones     = '1;
    reset_n  = 1'b0;
    start    = 1'b0;
    ack      = 1'b0;
    opA      = '0;
    opB      = '0;
    carry_in = 1'b0;
    obs_cin  = '0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;

    // Scenario 1: 1 + 2.
    issue(W'(1), W'(2), 1'b0);
    wait_done(n);
    check("s1_latency", 256'(n), 256'(WORDS));
    check("s1_result", 256'(result), 256'(3));
    check("s1_cout", 256'(carry_out), 256'(0));
    check("s1_model", 256'(model_sum(W'(1), W'(2), 1'b0)), 256'(3));
    give_ack();

    // Scenario 2: carry ripples out of word 0 only.
    issue(W'(32'hFFFF_FFFF), W'(1), 1'b0);
    wait_done(n);
    check("s2_result", 256'(result), 256'(64'h1_0000_0000));
    check("s2_cout", 256'(carry_out), 256'(0));
    check("s2_cin_words", 256'(obs_cin), 256'(4'b0010));
    give_ack();

    // Scenario 3: all ones + 0 + 1 wraps to zero with a final carry.
    issue(ones, '0, 1'b1);
    wait_done(n);
    check("s3_result", 256'(result), 256'(0));
    check("s3_cout", 256'(carry_out), 256'(1));
    check("s3_cin_words", 256'(obs_cin), 256'(4'b1111));
    check("s3_model", 256'(model_sum(ones, '0, 1'b1)), 256'({1'b1, {W{1'b0}}}));
    give_ack();

    // Scenario 4: reset while word 2 is in flight, then 5 + 7 right after.
    issue(rand_w(), rand_w(), 1'b1);
    repeat (2) begin @(posedge clock); #1; end
    reset_n = 1'b0;
    #1;
    check("s4_ready", 256'(ready), 256'(0));
    check("s4_done", 256'(done), 256'(0));
    check("s4_result", 256'({carry_out, result}), 256'(0));
    check("s4_add", 256'({add_cin, add_a, add_b}), 256'(0));
    @(posedge clock); #1;
    reset_n  = 1'b1;
    issue(W'(5), W'(7), 1'b0);
    wait_done(n);
    check("s4_latency", 256'(n), 256'(WORDS));
    check("s4_result12", 256'(result), 256'(12));
    give_ack();

    // Scenario 5: hold done 10 cycles with toggling operands.
    issue(W'(100), W'(23), 1'b0);
    wait_done(n);
    for (int i = 0; i < 10; i++) begin
      opA = ~opA;
      opB = rand_w();
      @(posedge clock); #1;
    end
    check("s5_hold_result", 256'(result), 256'(123));
    check("s5_hold_done", 256'(done), 256'(1));
    ack   = 1'b1;
    start = 1'b1;
    opA   = W'(9);
    opB   = W'(1);
    carry_in = 1'b0;
    @(posedge clock); #1;
    ack = 1'b0;
    check("s5_ack_ready", 256'(ready), 256'(1));
    check("s5_ack_done", 256'(done), 256'(0));
    @(posedge clock); #1;
    start = 1'b0;
    check("s5_accepted", 256'(ready), 256'(0));
    wait_done(n);
    check("s5_result10", 256'(result), 256'(10));
    give_ack();

    // Scenario 6: ack in IDLE, ack and start in RUN are ignored.
    give_ack();
    check("s6_idle_ready", 256'(ready), 256'(1));
    issue(W'(32'h8000_0000), W'(32'h8000_0000), 1'b1);
    ack   = 1'b1;
    start = 1'b1;
    @(posedge clock); #1;
    ack   = 1'b0;
    start = 1'b0;
    wait_done(n);
    check("s6_latency", 256'(n), 256'(WORDS - 1));
    check("s6_result", 256'(result), 256'(64'h1_0000_0001));
    give_ack();

    // Random operations with random noise on start/ack and random ack delay.
    for (int t = 0; t < 40; t++) begin
      logic [W-1:0] a, b;
      a = rand_w();
      b = rand_w();
      if (t % 8 == 0) a = ones;
      if (t % 8 == 1) b = ~a;
      issue(a, b, 1'($urandom));
      for (int k = 0; k < WORDS - 1; k++) begin
        start = 1'($urandom);
        ack   = 1'($urandom);
        @(posedge clock); #1;
      end
      start = 1'b0;
      ack   = 1'b0;
      wait_done(n);
      repeat ($urandom_range(0, 3)) begin
        opA = rand_w();
        @(posedge clock); #1;
      end
      give_ack();
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_seq128.md
ADD_SEQ128 -- requirements
Module: add_seq128

Interface
REQ-001 The block SHALL be parameterised as: WORDS, default 4, number of 32-bit words per operand; total operand width W = 32*WORDS.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Ports SHALL be (name  direction  width  meaning):
- clock  in  1  sole clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  operation request
- ready  out  1  block can accept start
- opA  in  W  operand A
- opB  in  W  operand B
- carry_in  in  1  carry into least-significant word
- add_a  out  32  word of A to downstream 32-bit adder
- add_b  out  32  word of B to downstream 32-bit adder
- add_cin  out  1  carry to downstream adder
- add_sum  in  32  adder sum, combinational on add_a/add_b/add_cin
- add_cout  in  1  adder carry out, combinational
- result  out  W  assembled sum
- carry_out  out  1  final carry
- done  out  1  result valid
- ack  in  1  result consumed

Function
REQ-004 The block SHALL implement states IDLE, RUN, DONE with a word index idx of ceil(log2(WORDS)) bits.
REQ-005 ready SHALL be 1 exactly when the state is IDLE and reset_n is 1.
REQ-006 In IDLE, start=1 at a rising edge SHALL latch opA, opB and carry_in into internal registers, clear result to 0, set idx=0, and enter RUN.
REQ-007 start SHALL be ignored in RUN and DONE; opA/opB/carry_in changes after acceptance SHALL NOT affect the operation.
REQ-008 In RUN, add_a and add_b SHALL be word idx (bits 32*idx+31:32*idx) of the latched A and B.
REQ-009 In RUN, add_cin SHALL be the latched carry_in when idx=0, else the carry captured from the previous word.
REQ-010 Each RUN edge SHALL write add_sum into result word idx and capture add_cout as the inter-word carry.
REQ-011 At the RUN edge with idx=WORDS-1, the block SHALL load carry_out with add_cout and enter DONE; otherwise idx SHALL increment by 1.
REQ-012 done SHALL assert exactly WORDS rising edges after the accepting edge: 4 with default WORDS.
REQ-013 add_a, add_b and add_cin SHALL be 0 in IDLE and DONE.
REQ-014 In DONE, done SHALL be 1, and result and carry_out SHALL hold stable until ack.
REQ-015 ack=1 in DONE SHALL return the block to IDLE at that edge; ready SHALL be 1 in the following cycle.
REQ-016 ack SHALL be ignored outside DONE.
REQ-017 If start and ack are both 1 in DONE, ack SHALL be honoured and start ignored.
REQ-018 The minimum issue interval SHALL be WORDS+2 cycles (accept, WORDS RUN, DONE with ack).
REQ-019 Arithmetic SHALL be unsigned modulo 2^W; carry_out SHALL equal bit W of opA+opB+carry_in.

Reset
REQ-020 While reset_n=0, regardless of clock, state SHALL be IDLE, idx, result, carry_out, done, add_a, add_b, add_cin and the internal registers SHALL be 0, and ready SHALL be 0.
REQ-021 Reset asserted mid-RUN or in DONE SHALL abandon the operation with no partial result retained.
REQ-022 The first rising edge after reset_n deasserts SHALL accept start if start=1.

Verification
REQ-023 Scenario 1: opA=1, opB=2, carry_in=0 -> result=3, carry_out=0, done 4 edges after accept.
REQ-024 Scenario 2: opA=0x...0000_FFFF_FFFF, opB=1, carry_in=0 -> add_cin=1 on word 1, result=0x1_0000_0000, carry_out=0.
REQ-025 Scenario 3: opA=all ones, opB=0, carry_in=1 -> result=0, carry_out=1, add_cin=1 on every word.
REQ-026 Scenario 4: reset_n pulsed low while idx=2 -> all outputs 0 immediately, state IDLE; a following 5+7 operation returns 12.
REQ-027 Scenario 5: hold done without ack for 10 cycles with opA/opB toggling -> result/carry_out stable. Then ack=1 and start=1 together -> one return to IDLE, no new operation; start next cycle is accepted.
REQ-028 Scenario 6: ack=1 pulsed in IDLE and RUN, and start pulsed in RUN -> no state change; the in-flight result is correct.
